// File: rtl/fetch_queue.sv
// Instruction-fetch stage: a free-running PC generator feeding a DEPTH-entry
// queue that absorbs decode stalls; a redirect flushes the queue and restarts fetch.
module fetch_queue #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          address_imem,
  input  logic [DATA_W-1:0]          q_imem,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [DATA_W-1:0]          deq_insn,
  output logic [ADDR_W-1:0]          deq_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Pointers wrap naturally because DEPTH is a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  // Sequential PC step; all-ones wraps silently to zero.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

  logic [ADDR_W-1:0] pc_p0;

  logic [DATA_W-1:0] insn_mem_p1 [DEPTH];
  logic [ADDR_W-1:0] pc_mem_p1   [DEPTH];
  logic [PTR_W-1:0]  head_p1;
  logic [PTR_W-1:0]  tail_p1;
  logic [CNT_W-1:0]  count_p1;
  logic              vld_p1;
  logic              full_p1;

  logic              deq;
  logic              enq;
  logic [CNT_W-1:0]  count_nxt;

  assign vld_p1  = (count_p1 != '0);
  assign full_p1 = (count_p1 == DEPTH_C);

  assign deq = vld_p1 && deq_ready && !redirect_valid;
  assign enq = !redirect_valid && (!full_p1 || deq);

  always_comb begin
    count_nxt = count_p1;
    if (redirect_valid) begin
      count_nxt = '0;
    end else begin
      case ({enq, deq})
        2'b10:   count_nxt = count_p1 + CNT_W'(1);
        2'b01:   count_nxt = count_p1 - CNT_W'(1);
        default: count_nxt = count_p1;
      endcase
    end
  end

  // ---- stage p0: fetch PC ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else if (redirect_valid) begin
      pc_p0 <= redirect_pc;
    end else if (enq) begin
      pc_p0 <= pc_inc(pc_p0);
    end
  end

  // ---- stage p1: instruction queue ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_p1  <= '0;
      tail_p1  <= '0;
      count_p1 <= '0;
    end else begin
      count_p1 <= count_nxt;
      if (redirect_valid) begin
        head_p1 <= '0;
        tail_p1 <= '0;
      end else begin
        if (deq) head_p1 <= ptr_inc(head_p1);
        if (enq) tail_p1 <= ptr_inc(tail_p1);
      end
    end
  end

  // Storage is cleared on reset so the head reads zero before the first fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        insn_mem_p1[i] <= '0;
        pc_mem_p1[i]   <= '0;
      end
    end else if (enq) begin
      insn_mem_p1[tail_p1] <= q_imem;
      pc_mem_p1[tail_p1]   <= pc_p0;
    end
  end

  assign address_imem = pc_p0;
  assign deq_valid    = vld_p1;
  assign deq_insn     = insn_mem_p1[head_p1];
  assign deq_pc       = pc_mem_p1[head_p1];
  assign count        = count_p1;
  assign full         = full_p1;
  assign empty        = !vld_p1;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: free-run, back-pressure, full-queue flow,
// redirect, PC wrap (narrow instance) and asynchronous reset.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_imem;
  logic [31:0] q_imem;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_insn;
  logic [31:0] deq_pc;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  logic [3:0]  w_address_imem;
  logic [31:0] w_q_imem;
  logic        w_redirect_valid = 1'b0;
  logic [3:0]  w_redirect_pc = 4'd0;
  logic        w_deq_ready = 1'b1;
  logic        w_deq_valid;
  logic [31:0] w_deq_insn;
  logic [3:0]  w_deq_pc;
  logic [2:0]  w_count;
  logic        w_full;
  logic        w_empty;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Combinational imem: instruction word = address + 100.
  assign q_imem   = address_imem + 32'd100;
  assign w_q_imem = {28'd0, w_address_imem} + 32'd100;

  fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_ready(deq_ready),
    .deq_valid(deq_valid), .deq_insn(deq_insn), .deq_pc(deq_pc),
    .count(count), .full(full), .empty(empty)
  );

  fetch_queue #(.DATA_W(32), .ADDR_W(4), .DEPTH(4), .RESET_PC(4'd14)) dut_w (
    .clock(clock), .reset(reset), .address_imem(w_address_imem), .q_imem(w_q_imem),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .deq_ready(w_deq_ready),
    .deq_valid(w_deq_valid), .deq_insn(w_deq_insn), .deq_pc(w_deq_pc),
    .count(w_count), .full(w_full), .empty(w_empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    deq_ready      = 1'b1;
    repeat (2) step();

    chk("rst_addr",   64'(address_imem), 64'd0);
    chk("rst_count",  64'(count),        64'd0);
    chk("rst_full",   64'(full),         64'd0);
    chk("rst_empty",  64'(empty),        64'd1);
    chk("rst_valid",  64'(deq_valid),    64'd0);
    chk("rst_insn",   64'(deq_insn),     64'd0);
    chk("rst_pc",     64'(deq_pc),       64'd0);
    chk("rst_w_addr", 64'(w_address_imem), 64'd14);

    reset = 1'b0;

    // Free run: one instruction per cycle, count pinned at 1.
    for (int k = 0; k < 6; k++) begin
      step();
      chk("run_valid", 64'(deq_valid),    64'd1);
      chk("run_pc",    64'(deq_pc),       64'(k));
      chk("run_insn",  64'(deq_insn),     64'(k + 100));
      chk("run_count", 64'(count),        64'd1);
      chk("run_addr",  64'(address_imem), 64'(k + 1));
      if (k < 4) begin
        chk("wrap_pc",   64'(w_deq_pc),   64'((14 + k) % 16));
        chk("wrap_insn", 64'(w_deq_insn), 64'(((14 + k) % 16) + 100));
      end
    end

    // Back-pressure: head stays at PC 5, queue fills, PC freezes at 9.
    deq_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_count", 64'(count),        64'((i + 2 > 4) ? 4 : i + 2));
      chk("bp_addr",  64'(address_imem), 64'(6 + ((i + 1 > 3) ? 3 : i + 1)));
      chk("bp_head",  64'(deq_pc),       64'd5);
      chk("bp_full",  64'(full),         64'((i >= 2) ? 1 : 0));
    end

    // Full with simultaneous dequeue: count holds, fetch continues in order.
    deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ff_count", 64'(count),        64'd4);
      chk("ff_full",  64'(full),         64'd1);
      chk("ff_pc",    64'(deq_pc),       64'(6 + i));
      chk("ff_insn",  64'(deq_insn),     64'(106 + i));
      chk("ff_addr",  64'(address_imem), 64'(10 + i));
    end

    // Redirect while full with deq_ready high.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("rd_empty", 64'(empty),        64'd1);
    chk("rd_valid", 64'(deq_valid),    64'd0);
    chk("rd_count", 64'(count),        64'd0);
    chk("rd_addr",  64'(address_imem), 64'h40);
    step();
    chk("rd1_valid", 64'(deq_valid),    64'd1);
    chk("rd1_pc",    64'(deq_pc),       64'h40);
    chk("rd1_insn",  64'(deq_insn),     64'hA4);
    chk("rd1_addr",  64'(address_imem), 64'h41);
    step();
    chk("rd2_pc",    64'(deq_pc),       64'h41);
    chk("rd2_count", 64'(count),        64'd1);

    // Build count=3, then pulse reset between clock edges.
    deq_ready = 1'b0;
    step();
    step();
    chk("pre_count", 64'(count), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("ar_addr",  64'(address_imem), 64'd0);
    chk("ar_count", 64'(count),        64'd0);
    chk("ar_full",  64'(full),         64'd0);
    chk("ar_empty", 64'(empty),        64'd1);
    chk("ar_valid", 64'(deq_valid),    64'd0);
    chk("ar_insn",  64'(deq_insn),     64'd0);
    chk("ar_pc",    64'(deq_pc),       64'd0);
    #1 reset = 1'b0;
    step();
    chk("post_valid", 64'(deq_valid),    64'd1);
    chk("post_pc",    64'(deq_pc),       64'd0);
    chk("post_insn",  64'(deq_insn),     64'd100);
    chk("post_count", 64'(count),        64'd1);
    chk("post_addr",  64'(address_imem), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
